// File: rtl/audio_dac_serializer_pkg.sv
// audio_pkg: shared FSM state type and default sizes for the audio DAC serializer
package audio_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} dac_state_t;
  localparam int AUDIO_SAMPLE_WIDTH = 32;
  localparam int AUDIO_FIFO_DEPTH = 8;
  localparam int AUDIO_UNDERFLOW_WIDTH = 8;
endpackage

// File: rtl/audio_dac_serializer_sync.sv
// sync_edge_detect: 2-flop synchronizer with registered-history rise/fall pulses
module sync_edge_detect (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s0, s1, prev;
  always_ff @(posedge CLOCK_50)
    if (reset) {s0, s1, prev} <= 3'b000;
    else {s0, s1, prev} <= {din, s0, s1};
  assign rise = s1 & ~prev;
  assign fall = ~s1 & prev;
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: FIFO-buffered I2S DAC serializer; AUDIO_DAC_UNDERRUN_REPEAT_EN replays the last pair on underflow
module audio_dac_serializer import audio_pkg::*; #(
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic [SAMPLE_WIDTH-1:0] left_channel_audio_out,
  input  logic [SAMPLE_WIDTH-1:0] right_channel_audio_out,
  input  logic write_audio_out,
  input  logic clear_audio_out_memory,
  output logic audio_out_allowed,
  input  logic AUD_BCLK,
  input  logic AUD_DACLRCK,
  output logic AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [AUDIO_UNDERFLOW_WIDTH-1:0] underflow_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam logic [CW-1:0] SAT = CW'(SAMPLE_WIDTH);
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [PW-1:0] pair;
  logic [SAMPLE_WIDTH-1:0] shreg, hold;
  logic [CW-1:0] cnt;
  dac_state_t state;
  logic bclk_fall, lrck_fall, lrck_rise, flush, push, pop, empty;
  sync_edge_detect u_bclk (.CLOCK_50(CLOCK_50), .reset(reset), .din(AUD_BCLK), .rise(), .fall(bclk_fall));
  sync_edge_detect u_lrck (.CLOCK_50(CLOCK_50), .reset(reset), .din(AUD_DACLRCK), .rise(lrck_rise), .fall(lrck_fall));
  assign flush = reset | clear_audio_out_memory;
  assign empty = fifo_level == '0;
  assign push = write_audio_out & audio_out_allowed & ~flush;
  assign pop = lrck_fall & ~empty & ~flush;
  assign level_nxt = fifo_level + LW'(push) - LW'(pop);
`ifdef AUDIO_DAC_UNDERRUN_REPEAT_EN
  logic [PW-1:0] last_pair;
  always_ff @(posedge CLOCK_50)
    if (flush) last_pair <= '0;
    else if (pop) last_pair <= mem[rd_ptr];
  assign pair = pop ? mem[rd_ptr] : last_pair;
`else
  assign pair = pop ? mem[rd_ptr] : '0;
`endif
  always_ff @(posedge CLOCK_50)
    if (push) mem[wr_ptr] <= {left_channel_audio_out, right_channel_audio_out};
  always_ff @(posedge CLOCK_50)
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      audio_out_allowed <= ~reset;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= level_nxt;
      audio_out_allowed <= level_nxt != LW'(FIFO_DEPTH);
    end
  always_ff @(posedge CLOCK_50)
    if (flush) begin
      state <= IDLE;
      shreg <= '0;
      hold <= '0;
      cnt <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (lrck_fall) begin
      state <= LEFT;
      shreg <= pair[PW-1:SAMPLE_WIDTH];
      hold <= pair[SAMPLE_WIDTH-1:0];
      cnt <= '0;
    end else if (lrck_rise) begin
      cnt <= '0;
      if (state == LEFT) begin
        state <= RIGHT;
        shreg <= hold;
      end
    end else if (bclk_fall && state != IDLE) begin
      AUD_DACDAT <= (cnt != SAT) & shreg[SAMPLE_WIDTH-1];
      shreg <= shreg << 1;
      cnt <= cnt + CW'(cnt != SAT);
    end
  always_ff @(posedge CLOCK_50)
    if (reset) underflow_count <= '0;
    else if (lrck_fall && empty && !clear_audio_out_memory && underflow_count != '1)
      underflow_count <= underflow_count + AUDIO_UNDERFLOW_WIDTH'(1);
endmodule
